// File: rtl/mcu_in_port.sv
// rtl/mcu_in_port.sv - MCU input port: pin synchronizer, button debouncer, capture register and read port
module mcu_in_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [7:0]  DATA_ADDR       = 8'hFF,
    parameter logic [7:0]  STATUS_ADDR     = 8'hFE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] fpga_in,
    input  logic [0:7] read_address,
    input  logic       read_enable,
    output logic [0:7] input_data_out,
    output logic       in_valid,
    output logic       overrun
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [8:0] sync1;
    logic [8:0] sync2;
    logic [7:0] data_s2;
    logic       strb_s2;

    logic       stable;
    logic [7:0] cnt;
    logic [7:0] hold;

    logic       accept;
    logic       rise;
    logic       data_rd;
    logic       stat_rd;

    assign data_s2 = sync2[7:0];
    assign strb_s2 = sync2[8];

    always_comb begin
        accept  = (strb_s2 != stable) && (cnt == CNT_LAST);
        rise    = accept && strb_s2;
        data_rd = read_enable && (read_address == DATA_ADDR);
        stat_rd = read_enable && (read_address == STATUS_ADDR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 9'h000;
            sync2 <= 9'h000;
        end else begin
            sync1 <= fpga_in;
            sync2 <= sync1;
        end
    end

    // Any sample equal to the accepted level restarts the count, so a bounce never accumulates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stable <= 1'b0;
            cnt    <= 8'h00;
        end else if (strb_s2 == stable) begin
            cnt <= 8'h00;
        end else if (accept) begin
            stable <= strb_s2;
            cnt    <= 8'h00;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // A capture beats a same-edge data read: the old byte counts as consumed, so no overrun.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold     <= 8'h00;
            in_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (rise) begin
                hold     <= data_s2;
                in_valid <= 1'b1;
            end else if (data_rd) begin
                in_valid <= 1'b0;
            end

            if (rise && in_valid && !data_rd) begin
                overrun <= 1'b1;
            end else if (stat_rd) begin
                overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            input_data_out <= 8'h00;
        end else if (read_address == DATA_ADDR) begin
            input_data_out <= hold;
        end else if (read_address == STATUS_ADDR) begin
            input_data_out <= {6'b000000, overrun, in_valid};
        end else begin
            input_data_out <= 8'h00;
        end
    end

endmodule
